// File: rtl/instr_fetch_if.sv
// Fetch-to-decode interface: the registered instruction slot, its valid/ready
// handshake, and the misaligned-redirect halt status.
//   if_valid       master->slave  if_instr/if_pc hold a valid instruction
//   if_ready       slave->master  decode accepts this cycle
//   if_instr       master->slave  fetched instruction word
//   if_pc          master->slave  byte address of if_instr
//   if_misaligned  master->slave  fetch halted on a misaligned redirect target
//   if_bad_pc      master->slave  offending redirect target while halted
interface instr_fetch_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_misaligned;
  logic [31:0] if_bad_pc;

  modport master (
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_misaligned,
    output if_bad_pc
  );

  modport slave (
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_misaligned,
    input  if_bad_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the rv32i core. Owns the PC, addresses the
// combinational-read program memory and registers the returned word toward
// decode, honouring decode back-pressure, execute redirects and misaligned
// redirect targets (which halt fetching). Counts completed decode handshakes.
//   clk, rst_n      clock, synchronous active-low reset
//   imem_addr       byte address to program memory (the pc register)
//   imem_data       instruction word for imem_addr
//   redirect_valid  execute requests a PC change
//   redirect_pc     redirect target
//   fb              fetch-to-decode interface (master side)
//   fetch_count     number of completed if_valid & if_ready handshakes
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [31:0]         imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  instr_fetch_if.master       fb,
  output logic [31:0]         fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   bad_q, bad_d;
  logic [XLEN-1:0]   count_q, count_d;

  logic handshake;
  logic accept;

  assign handshake = valid_q & fb.if_ready;
  assign accept    = ~valid_q | fb.if_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSN;
      out_pc_q <= RESET_PC;
      mis_q    <= 1'b0;
      bad_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
      mis_q    <= mis_d;
      bad_q    <= bad_d;
      count_q  <= count_d;
    end
  end

  // Next-state: redirect first, then capture/hold depending on state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    out_pc_d = out_pc_q;
    mis_d    = mis_q;
    bad_d    = bad_q;
    count_d  = count_q;

    // A handshake in the same cycle as a redirect still consumes the word.
    if (handshake) begin
      count_d = count_q + XLEN'(1);
    end

    if (redirect_valid) begin
      valid_d = 1'b0;
      pc_d    = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        state_d = RUN;
        mis_d   = 1'b0;
      end else begin
        state_d = HALT;
        mis_d   = 1'b1;
        bad_d   = redirect_pc;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept) begin
            instr_d  = imem_data;
            out_pc_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + XLEN'(4);
          end
        end
        HALT: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign imem_addr        = pc_q;
  assign fb.if_valid      = valid_q;
  assign fb.if_instr      = instr_q;
  assign fb.if_pc         = out_pc_q;
  assign fb.if_misaligned = mis_q;
  assign fb.if_bad_pc     = bad_q;
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a small program-memory model.
module tb_instr_fetch;
  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  int total;
  int bad;

  instr_fetch_if fif ();

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .NOP_INSN(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fb            (fif.master),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: a few known words, a distinct filler elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2000_0513;
      32'h0000_0004: mem_word = 32'h0040_0593;
      32'h0000_0008: mem_word = 32'h2040_0693;
      32'h0000_0054: mem_word = 32'h0000_006F;
      32'hFFFF_FFFC: mem_word = 32'hCAFE_F00D;
      default:       mem_word = 32'h1000_0000 | a;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    fif.if_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_valid", 32'(fif.if_valid), 32'd0);
    chk("rst_instr", fif.if_instr, 32'h0000_0013);
    chk("rst_pc", fif.if_pc, 32'h0);
    chk("rst_mis", 32'(fif.if_misaligned), 32'd0);
    chk("rst_bad", fif.if_bad_pc, 32'h0);
    chk("rst_cnt", fetch_count, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // 1: streaming fetch
    rst_n = 1'b1;
    fif.if_ready = 1'b1;
    step();
    chk("t1_valid", 32'(fif.if_valid), 32'd1);
    chk("t1_pc0", fif.if_pc, 32'h0);
    chk("t1_instr0", fif.if_instr, 32'h2000_0513);
    chk("t1_cnt0", fetch_count, 32'd0);
    step();
    chk("t1_pc1", fif.if_pc, 32'h4);
    chk("t1_instr1", fif.if_instr, 32'h0040_0593);
    chk("t1_cnt1", fetch_count, 32'd1);

    // 2: back-pressure hold
    fif.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_pc", fif.if_pc, 32'h4);
      chk("t2_hold_instr", fif.if_instr, 32'h0040_0593);
      chk("t2_hold_addr", imem_addr, 32'h8);
      chk("t2_hold_cnt", fetch_count, 32'd1);
    end
    fif.if_ready = 1'b1;
    step();
    chk("t2_pc", fif.if_pc, 32'h8);
    chk("t2_instr", fif.if_instr, 32'h2040_0693);
    chk("t2_cnt", fetch_count, 32'd2);
    step();
    step();
    step();
    chk("t2_pc_run", fif.if_pc, 32'h14);
    chk("t2_cnt5", fetch_count, 32'd5);

    // 3: redirect during a stall flushes the held word
    fif.if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h54;
    step();
    chk("t3_flush_valid", 32'(fif.if_valid), 32'd0);
    chk("t3_addr", imem_addr, 32'h54);
    chk("t3_cnt", fetch_count, 32'd5);
    redirect_valid = 1'b0;
    fif.if_ready = 1'b1;
    step();
    chk("t3_valid", 32'(fif.if_valid), 32'd1);
    chk("t3_pc", fif.if_pc, 32'h54);
    chk("t3_instr", fif.if_instr, 32'h0000_006F);
    chk("t3_cnt2", fetch_count, 32'd5);

    // 4: misaligned redirect halts; handshake in same cycle still counts
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    step();
    chk("t4_mis", 32'(fif.if_misaligned), 32'd1);
    chk("t4_bad", fif.if_bad_pc, 32'h22);
    chk("t4_valid", 32'(fif.if_valid), 32'd0);
    chk("t4_cnt", fetch_count, 32'd6);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_halt_valid", 32'(fif.if_valid), 32'd0);
      chk("t4_halt_mis", 32'(fif.if_misaligned), 32'd1);
      chk("t4_halt_addr", imem_addr, 32'h22);
    end
    chk("t4_halt_cnt", fetch_count, 32'd6);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    chk("t4_unmis", 32'(fif.if_misaligned), 32'd0);
    chk("t4_addr0", imem_addr, 32'h0);
    redirect_valid = 1'b0;
    step();
    chk("t4_resume_valid", 32'(fif.if_valid), 32'd1);
    chk("t4_resume_instr", fif.if_instr, 32'h2000_0513);
    chk("t4_resume_pc", fif.if_pc, 32'h0);

    // 5: pc wraps at 2^32
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t5_cnt", fetch_count, 32'd7);
    redirect_valid = 1'b0;
    step();
    chk("t5_pc", fif.if_pc, 32'hFFFF_FFFC);
    chk("t5_instr", fif.if_instr, 32'hCAFE_F00D);
    chk("t5_wrap_addr", imem_addr, 32'h0);
    step();
    chk("t5_wrap_pc", fif.if_pc, 32'h0);
    chk("t5_wrap_instr", fif.if_instr, 32'h2000_0513);
    chk("t5_cnt2", fetch_count, 32'd8);

    // 6: reset mid-stall with a pending redirect
    fif.if_ready = 1'b0;
    step();
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    chk("t6_valid", 32'(fif.if_valid), 32'd0);
    chk("t6_instr", fif.if_instr, 32'h0000_0013);
    chk("t6_pc", fif.if_pc, 32'h0);
    chk("t6_mis", 32'(fif.if_misaligned), 32'd0);
    chk("t6_bad", fif.if_bad_pc, 32'h0);
    chk("t6_cnt", fetch_count, 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    fif.if_ready = 1'b1;
    step();
    chk("t6_run_valid", 32'(fif.if_valid), 32'd1);
    chk("t6_run_instr", fif.if_instr, 32'h2000_0513);
    chk("t6_run_addr", imem_addr, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
